flashrom_reader: RTL and testbench
==================================

# flashrom_reader

Wishbone initiator that fetches a run of bytes from the 8-bit, 7-bit-addressed boot flash ROM responder and packs them into big-endian 32-bit words delivered on a valid/ready stream. It sits between the flash ROM slave port and the boot-copy / configuration logic. Callers issue a single start command instead of running byte-wide bus cycles themselves. The block handles ack, error, retry and no-response timeout.

## Interface
- AW, 7: byte address width on the bus; the address wraps modulo 2^AW.
- TIMEOUT, 255: maximum cycles with stb high and no ack/err/rty before the access is aborted.
- MAX_RTY, 3: retries allowed per byte before the run is aborted.
- wb_clk  in  1  sole clock; all state updates on rising edge.
- wb_rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle command pulse; ignored while busy_o=1.
- start_adr_i  in  AW  first byte address, sampled with start_i.
- word_cnt_i  in  6  words to fetch, sampled with start_i. Values above 32 are clamped to 32. A value of 0 fetches nothing.
- wb_adr_o  out  AW  byte address.
- wb_cyc_o / wb_stb_o  out  1  bus cycle / strobe, always driven equal.
- wb_we_o  out  1  constant 0.
- wb_dat_i  in  8  read data, valid with wb_ack_i.
- wb_ack_i / wb_err_i / wb_rty_i  in  1  responder termination.
- word_o  out  32  packed word. The first-fetched byte is in [31:24].
- word_valid_o  out  1  word available.
- word_ready_i  in  1  consumer accepts the word when valid and ready are both high.
- word_last_o  out  1  high with the final word of a run.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse at the end of a run, success or abort.
- err_o  out  1  sticky abort flag; cleared by the next accepted start_i.

## Operation
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- FSM states: IDLE, REQ, GAP, PUSH, FIN.
- IDLE:
  - start_i with clamped count 0 -> FIN. No bus cycle is issued.
  - start_i with nonzero count -> latch address and count, clear err_o, enter REQ.
- REQ:
  - cyc/stb are high with the current address; the timeout counter runs.
  - ack -> write wb_dat_i into byte lane (3 - byte_idx), advance the address (wrapping), then go to GAP.
  - rty -> go to GAP without advancing; the retry counter increments.
  - err, or rty with retry counter = MAX_RTY, or timeout counter = TIMEOUT -> set err_o, go to FIN.
  - When ack/err/rty arrive in the same cycle, priority is err > ack > rty.
- GAP:
  - Exactly one cycle with cyc/stb low, so a responder that restarts on continuous strobe sees a clean access.
  - If the word still needs bytes, or after a retry -> REQ.
  - If byte_idx has wrapped to 0 after a fourth ack -> PUSH.
- PUSH:
  - word_valid_o is high; word_o holds steady; word_last_o = (words remaining == 1).
  - On the accepting handshake, decrement the remaining count. If the count reaches 0 -> FIN, else -> REQ.
  - Back-pressure is unbounded; no bus activity occurs during PUSH.
- FIN: pulse done_o for one cycle, then return to IDLE.
- Counters and word data:
  - The retry and timeout counters clear on every ack and whenever REQ is entered from PUSH or IDLE.
  - A partially assembled word is discarded on abort and is never presented.
- busy_o is high in every state except IDLE.
- Asserting reset mid-run drops cyc/stb immediately (asynchronously), discards all data, and clears err_o.

## Timing
- A start_i at edge 0 puts stb high in the cycle after edge 0.
- Per byte: (responder ack latency) + 1 GAP cycle. Against the 4-cycle flash ROM responder, one word takes 20 cycles from REQ entry to word_valid_o.
- word_valid_o rises in the cycle after the GAP of the fourth byte.
- After an accepting handshake, the next REQ starts the following cycle.
- done_o comes 1 cycle after the last handshake, or 1 cycle after the abort condition.
- A start_i in the same cycle as done_o is ignored, because busy_o is still 1.

## Test plan
- Start at address 0x10, count 1, ROM bytes 0xDE 0xAD 0xBE 0xEF, ready held high:
  - exactly 4 bus cycles at addresses 0x10–0x13, separated by 1-cycle GAPs;
  - word_o = 0xDEADBEEF with word_last_o=1;
  - done_o 1 cycle after the handshake; err_o=0.
- Start at address 0x7E, count 2: addresses run 0x7E, 0x7F, 0x00 … 0x05 (wrap). Two words are delivered; only the second has word_last_o=1.
- Hold word_ready_i low for 50 cycles on word 1 of 3:
  - word_o is stable throughout and no stb is issued;
  - after release the remaining words follow;
  - count 40 is clamped to 32 words (128 bus reads).
- Responder asserts rty twice then ack on byte 2: the same address is re-requested and the word is correct. With 4 consecutive rty the run aborts: err_o=1, done_o pulses, no word is presented.
- Responder never acks: after TIMEOUT=255 stb cycles, stb drops, err_o=1 and done_o pulses. Asserting wb_err_i on byte 0 aborts the same way in the next cycle.
- Count 0 -> done_o the cycle after start with no bus activity. Reset pulse mid-REQ -> all outputs 0 at once, and a new start succeeds.

Source files
------------

// File: rtl/flashrom_reader_if.sv
// Byte-wide, read-only Wishbone link between flashrom_reader (master) and
// the boot flash ROM responder (slave).
interface flashrom_reader_if #(
    parameter int AW = 7
);
    logic [AW-1:0] adr;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [7:0]    dat;
    logic          ack;
    logic          err;
    logic          rty;

    modport master (output adr, cyc, stb, we, input dat, ack, err, rty);
    modport slave  (input adr, cyc, stb, we, output dat, ack, err, rty);
endinterface

// File: rtl/flashrom_reader.sv
// Fetches a run of bytes from the flash ROM over Wishbone and streams them out
// as big-endian 32-bit words, with retry, error and no-response timeout handling.
module flashrom_reader #(
    parameter int AW      = 7,
    parameter int TIMEOUT = 255,
    parameter int MAX_RTY = 3
) (
    input  logic                wb_clk,
    input  logic                wb_rst_n,
    input  logic                start_i,
    input  logic [AW-1:0]       start_adr_i,
    input  logic [5:0]          word_cnt_i,
    flashrom_reader_if.master   wb,
    output logic [31:0]         word_o,
    output logic                word_valid_o,
    input  logic                word_ready_i,
    output logic                word_last_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    typedef enum logic [2:0] {IDLE, REQ, GAP, PUSH, FIN} state_t;

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam int            RW       = $clog2(MAX_RTY + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RTY);

    state_t        state_q, state_d;
    logic [AW-1:0] adr_q;
    logic [5:0]    words_left_q;
    logic [1:0]    byte_idx_q;
    logic          full_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [RW-1:0] rty_cnt_q;
    logic [31:0]   word_q;
    logic          err_q;
    logic [5:0]    cnt_clamped;
    logic          abort;

    assign cnt_clamped = (word_cnt_i > 6'd32) ? 6'd32 : word_cnt_i;

    // err beats ack beats rty; timeout only counts cycles with no termination at all
    always_comb begin
        abort = 1'b0;
        if (state_q == REQ) begin
            if (wb.err)      abort = 1'b1;
            else if (wb.ack) abort = 1'b0;
            else if (wb.rty) abort = (rty_cnt_q == RTY_MAX);
            else             abort = (tmo_cnt_q == TMO_LAST);
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = (cnt_clamped == 6'd0) ? FIN : REQ;
            REQ: begin
                if (abort)                  state_d = FIN;
                else if (wb.ack || wb.rty)  state_d = GAP;
            end
            GAP:  state_d = full_q ? PUSH : REQ;
            PUSH: if (word_ready_i) state_d = (words_left_q == 6'd1) ? FIN : REQ;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb.cyc       = 1'b0;
        wb.stb       = 1'b0;
        word_valid_o = 1'b0;
        word_last_o  = 1'b0;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        case (state_q)
            IDLE: busy_o = 1'b0;
            REQ: begin
                wb.cyc = 1'b1;
                wb.stb = 1'b1;
            end
            PUSH: begin
                word_valid_o = 1'b1;
                word_last_o  = (words_left_q == 6'd1);
            end
            FIN: done_o = 1'b1;
            default: ;
        endcase
    end

    assign wb.we  = 1'b0;
    assign wb.adr = adr_q;
    assign word_o = word_q;
    assign err_o  = err_q;

    // full_q marks that the fourth ack landed, so GAP can tell a finished word
    // from a fresh one (byte_idx is 0 in both cases)
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            adr_q        <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            full_q       <= 1'b0;
            tmo_cnt_q    <= '0;
            rty_cnt_q    <= '0;
            word_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        err_q <= 1'b0;
                        if (cnt_clamped != 6'd0) begin
                            adr_q        <= start_adr_i;
                            words_left_q <= cnt_clamped;
                            byte_idx_q   <= '0;
                            full_q       <= 1'b0;
                            tmo_cnt_q    <= '0;
                            rty_cnt_q    <= '0;
                        end
                    end
                end
                REQ: begin
                    if (abort) begin
                        err_q  <= 1'b1;
                        word_q <= '0;
                    end else if (wb.ack) begin
                        word_q[{~byte_idx_q, 3'b000} +: 8] <= wb.dat;
                        adr_q      <= adr_q + 1'b1;
                        byte_idx_q <= byte_idx_q + 1'b1;
                        full_q     <= (byte_idx_q == 2'd3);
                        tmo_cnt_q  <= '0;
                        rty_cnt_q  <= '0;
                    end else if (wb.rty) begin
                        rty_cnt_q <= rty_cnt_q + 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                PUSH: begin
                    if (word_ready_i) begin
                        words_left_q <= words_left_q - 1'b1;
                        full_q       <= 1'b0;
                        tmo_cnt_q    <= '0;
                        rty_cnt_q    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flashrom_reader.sv
// Directed bench for flashrom_reader against a 4-cycle flash ROM responder model
// with injectable retry, error and no-response behaviour.
module tb_flashrom_reader;

    localparam int AW = 7;

    logic          wb_clk   = 1'b0;
    logic          wb_rst_n = 1'b0;
    logic          start_i  = 1'b0;
    logic [AW-1:0] start_adr_i = '0;
    logic [5:0]    word_cnt_i  = '0;
    logic [31:0]   word_o;
    logic          word_valid_o;
    logic          word_ready_i = 1'b0;
    logic          word_last_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    always #5 wb_clk = ~wb_clk;

    flashrom_reader_if #(.AW(AW)) wb ();

    flashrom_reader #(.AW(AW), .TIMEOUT(255), .MAX_RTY(3)) dut (
        .wb_clk       (wb_clk),
        .wb_rst_n     (wb_rst_n),
        .start_i      (start_i),
        .start_adr_i  (start_adr_i),
        .word_cnt_i   (word_cnt_i),
        .wb           (wb),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .word_last_o  (word_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    // Responder: terminates in the 4th consecutive stb cycle.
    // rsp_mode 0 = normal, 1 = never responds, 2 = err immediately.
    logic [7:0]    rom [128];
    int            rsp_cnt   = 0;
    int            rsp_mode  = 0;
    int            rty_left  = 0;
    logic [AW-1:0] rty_adr   = '0;

    assign wb.rty = wb.stb && (rsp_mode == 0) && (rsp_cnt == 3) && (rty_left > 0) && (wb.adr == rty_adr);
    assign wb.ack = wb.stb && (rsp_mode == 0) && (rsp_cnt == 3) && !wb.rty;
    assign wb.err = wb.stb && (rsp_mode == 2);
    assign wb.dat = wb.ack ? rom[wb.adr] : 8'h00;

    int n_vec = 0;
    int n_bad = 0;

    int            tk = 0;
    logic          s_stb, s_term, s_rty, s_vld, prev_stb;
    logic [31:0]   s_word;
    int            stb_cyc, stb_rise, first_stb_tk, last_stb_tk, first_vld_tk;
    int            hs_tk, done_tk, done_cnt, last_rty_tk, start_tk;
    int            stall_seen, stall_bad;
    logic [AW-1:0] ack_adr_q[$];
    logic [AW-1:0] rty_adr_q[$];
    logic [31:0]   word_q[$];
    logic          last_q[$];

    typedef struct {
        logic [AW-1:0] adr;
        logic [5:0]    cnt;
        int            stall;
        int            exp_words;
        int            exp_reads;
        logic [31:0]   exp_w0;
        logic [31:0]   exp_wl;
    } vec_t;
    vec_t vec [4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_rec();
        stb_cyc = 0; stb_rise = 0; first_stb_tk = -1; last_stb_tk = -1; first_vld_tk = -1;
        hs_tk = -1; done_tk = -1; done_cnt = 0; last_rty_tk = -1; prev_stb = 1'b0;
        stall_seen = 0; stall_bad = 0;
        ack_adr_q.delete(); rty_adr_q.delete(); word_q.delete(); last_q.delete();
    endtask

    // Observe one cycle at the falling edge, then advance past the rising edge.
    task automatic tick();
        @(negedge wb_clk);
        s_stb  = wb.stb;
        s_term = wb.ack | wb.err | wb.rty;
        s_rty  = wb.rty;
        s_vld  = word_valid_o;
        s_word = word_o;
        if (wb.stb) begin
            stb_cyc++;
            last_stb_tk = tk;
            if (!prev_stb) stb_rise++;
            if (first_stb_tk < 0) first_stb_tk = tk;
        end
        prev_stb = wb.stb;
        if (wb.ack) ack_adr_q.push_back(wb.adr);
        if (wb.rty) begin
            rty_adr_q.push_back(wb.adr);
            last_rty_tk = tk;
        end
        if (word_valid_o && first_vld_tk < 0) first_vld_tk = tk;
        if (word_valid_o && word_ready_i) begin
            word_q.push_back(word_o);
            last_q.push_back(word_last_o);
            hs_tk = tk;
        end
        if (done_o) begin
            done_cnt++;
            done_tk = tk;
        end
        @(posedge wb_clk);
        #1;
        rsp_cnt = (s_stb && !s_term) ? rsp_cnt + 1 : 0;
        if (s_rty) rty_left--;
        tk++;
    endtask

    logic [31:0] stall_word;

    task automatic do_run(input logic [AW-1:0] adr, input logic [5:0] cnt, input int stall, input int budget);
        clear_rec();
        start_adr_i  = adr;
        word_cnt_i   = cnt;
        word_ready_i = (stall == 0);
        start_i      = 1'b1;
        start_tk     = tk;
        tick();
        start_i = 1'b0;
        while (done_cnt == 0 && (tk - start_tk) < budget) begin
            tick();
            if (s_vld && !word_ready_i) begin
                if (stall_seen == 0) stall_word = s_word;
                else if (s_word !== stall_word) stall_bad++;
                if (s_stb) stall_bad++;
                stall_seen++;
            end
            word_ready_i = (stall_seen >= stall);
        end
        if (done_cnt == 0) check("done_within_budget", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 8'(i + 128);
        rom[7'h10] = 8'hDE; rom[7'h11] = 8'hAD; rom[7'h12] = 8'hBE; rom[7'h13] = 8'hEF;

        vec[0] = '{7'h10, 6'd1,  0,  1,   4, 32'hDEADBEEF, 32'hDEADBEEF};
        vec[1] = '{7'h7E, 6'd2,  0,  2,   8, 32'hFEFF8081, 32'h82838485};
        vec[2] = '{7'h40, 6'd3,  50, 3,  12, 32'hC0C1C2C3, 32'hC8C9CACB};
        vec[3] = '{7'h20, 6'd40, 0,  32, 128, 32'hA0A1A2A3, 32'h9C9D9E9F};

        clear_rec();
        tick(); tick();
        check("reset_outputs",
              32'({wb.cyc, wb.stb, wb.we, word_valid_o, word_last_o, busy_o, done_o, err_o}), 32'd0);
        check("reset_word_adr", word_o | 32'(wb.adr), 32'd0);
        wb_rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            int bad_words;
            int bad_adr;
            int n_last;
            do_run(vec[i].adr, vec[i].cnt, vec[i].stall, 2000);
            check("words", 32'(word_q.size()), 32'(vec[i].exp_words));
            check("reads", 32'(ack_adr_q.size()), 32'(vec[i].exp_reads));
            check("stb_bursts", 32'(stb_rise), 32'(vec[i].exp_reads));
            check("first_stb_lat", 32'(first_stb_tk - start_tk), 32'd1);
            check("first_valid_lat", 32'(first_vld_tk - start_tk), 32'd21);
            check("word_first", (word_q.size() > 0) ? word_q[0] : 32'hX, vec[i].exp_w0);
            check("word_final", (word_q.size() > 0) ? word_q[word_q.size()-1] : 32'hX, vec[i].exp_wl);
            bad_words = 0; bad_adr = 0; n_last = 0;
            for (int w = 0; w < word_q.size(); w++) begin
                logic [AW-1:0] a;
                a = vec[i].adr + AW'(4 * w);
                if (word_q[w] !== {rom[a], rom[a + 7'd1], rom[a + 7'd2], rom[a + 7'd3]}) bad_words++;
                if (last_q[w]) n_last++;
            end
            for (int k = 0; k < ack_adr_q.size(); k++)
                if (ack_adr_q[k] !== vec[i].adr + AW'(k)) bad_adr++;
            check("word_contents", 32'(bad_words), 32'd0);
            check("address_sequence", 32'(bad_adr), 32'd0);
            check("last_count", 32'(n_last), 32'd1);
            check("last_on_final", (last_q.size() > 0) ? 32'(last_q[last_q.size()-1]) : 32'hX, 32'd1);
            check("done_after_hs", 32'(done_tk - hs_tk), 32'd1);
            check("done_pulses", 32'(done_cnt), 32'd1);
            check("err_clean", 32'({err_o, busy_o}), 32'd0);
            if (vec[i].stall > 0) begin
                check("stall_cycles", 32'(stall_seen), 32'(vec[i].stall));
                check("stall_stable_no_stb", 32'(stall_bad), 32'd0);
            end
        end

        // Two retries on byte 2, then ack
        rty_adr = 7'h32; rty_left = 2;
        do_run(7'h30, 6'd1, 0, 500);
        check("rty2_count", 32'(rty_adr_q.size()), 32'd2);
        check("rty2_same_adr", (rty_adr_q.size() == 2) ? 32'({rty_adr_q[0], rty_adr_q[1]}) : 32'hX, 32'({7'h32, 7'h32}));
        check("rty2_reads", 32'(ack_adr_q.size()), 32'd4);
        check("rty2_bursts", 32'(stb_rise), 32'd6);
        check("rty2_word", (word_q.size() == 1) ? word_q[0] : 32'hX, 32'hB0B1B2B3);
        check("rty2_err", 32'(err_o), 32'd0);

        // Four retries on byte 1 abort the run
        rty_adr = 7'h31; rty_left = 4;
        do_run(7'h30, 6'd1, 0, 500);
        check("rty4_count", 32'(rty_adr_q.size()), 32'd4);
        check("rty4_reads", 32'(ack_adr_q.size()), 32'd1);
        check("rty4_no_word", 32'(first_vld_tk), 32'hFFFFFFFF);
        check("rty4_err", 32'({err_o, busy_o}), 32'b10);
        check("rty4_done_lat", 32'(done_tk - last_rty_tk), 32'd1);
        check("rty4_done_pulses", 32'(done_cnt), 32'd1);

        // Count 0: no bus activity, done next cycle, sticky err cleared by the start
        do_run(7'h10, 6'd0, 0, 50);
        check("cnt0_stb", 32'(stb_cyc), 32'd0);
        check("cnt0_done_lat", 32'(done_tk - start_tk), 32'd1);
        check("cnt0_err_cleared", 32'(err_o), 32'd0);

        // Responder never answers
        rsp_mode = 1;
        do_run(7'h10, 6'd1, 0, 400);
        check("tmo_stb_cycles", 32'(stb_cyc), 32'd255);
        check("tmo_done_lat", 32'(done_tk - last_stb_tk), 32'd1);
        check("tmo_err", 32'(err_o), 32'd1);
        check("tmo_no_word", 32'(word_q.size()), 32'd0);

        // Bus error on byte 0
        rsp_mode = 2;
        do_run(7'h10, 6'd1, 0, 50);
        check("err_stb_cycles", 32'(stb_cyc), 32'd1);
        check("err_done_lat", 32'(done_tk - last_stb_tk), 32'd1);
        check("err_flag", 32'(err_o), 32'd1);
        rsp_mode = 0;

        // Reset in the middle of a run, after the first byte has landed
        clear_rec();
        start_adr_i = 7'h10; word_cnt_i = 6'd2; word_ready_i = 1'b1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        check("pre_reset_in_req", 32'({wb.stb, ack_adr_q.size() == 1}), 32'b11);
        #2 wb_rst_n = 1'b0;
        #1;
        check("midrst_outputs",
              32'({wb.cyc, wb.stb, word_valid_o, word_last_o, busy_o, done_o, err_o}), 32'd0);
        check("midrst_word_adr", word_o | 32'(wb.adr), 32'd0);
        tick(); tick();
        wb_rst_n = 1'b1;
        tick();
        do_run(7'h10, 6'd1, 0, 200);
        check("post_rst_word", (word_q.size() == 1) ? word_q[0] : 32'hX, 32'hDEADBEEF);
        check("post_rst_done", 32'({done_cnt[1:0], err_o}), 32'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
